// File: rtl/game_pkg.sv
// Shared types and defaults for the game round controller: FSM state encoding,
// phase timing defaults and key bit positions.
package game_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StInit,
        StStart,
        StClrStart,
        StInstr,
        StWaitIn,
        StRelease,
        StClrInstr,
        StFeedback,
        StClrFeed,
        StDone
    } state_e;

    localparam int unsigned DefStartTicks = 3;
    localparam int unsigned DefFeedTicks  = 2;
    localparam int unsigned DefRespInit   = 5;
    localparam int unsigned DefRespMin    = 2;

    localparam int unsigned KEY_W = 0;
    localparam int unsigned KEY_A = 1;
    localparam int unsigned KEY_S = 2;
    localparam int unsigned KEY_D = 3;
    localparam int unsigned KEY_R = 4;
    localparam int unsigned KEY_L = 5;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter clocked by the tick enable; flags expiry on the tick
// that ends the phase, or at once if loaded with zero.
module phase_timer #(
    parameter int unsigned TICK_W = 8
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              load_i,
    input  logic [TICK_W-1:0] load_val_i,
    input  logic              tick_i,
    output logic              expire_o
);

    logic [TICK_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (tick_i && (count_q != '0)) begin
            count_d = count_q - TICK_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = (tick_i && (count_q == TICK_W'(1))) || (count_q == '0);

endmodule

// File: rtl/game_round_controller.sv
// Round sequencer: start screen, instruction, response capture, feedback and
// clears, with a shrinking response window, lives, score and game-over.
module game_round_controller
    import game_pkg::*;
#(
    parameter int unsigned NUM_KEYS    = 6,
    parameter int unsigned ROUNDS      = 16,
    parameter int unsigned LIVES       = 3,
    parameter int unsigned TICK_W      = 8,
    parameter int unsigned START_TICKS = DefStartTicks,
    parameter int unsigned FEED_TICKS  = DefFeedTicks,
    parameter int unsigned RESP_INIT   = DefRespInit,
    parameter int unsigned RESP_MIN    = DefRespMin,
    localparam int unsigned CNT_W      = $clog2(ROUNDS + 1),
    localparam int unsigned LIV_W      = $clog2(LIVES + 1)
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                start_i,
    input  logic                tick_i,
    input  logic [NUM_KEYS-1:0] user_input_i,
    input  logic [NUM_KEYS-1:0] expected_mask_i,
    input  logic                expect_none_i,
    input  logic                clear_done_i,
    output logic                enable_start_o,
    output logic                enable_instruction_o,
    output logic                enable_feedback_o,
    output logic                clear_req_o,
    output logic                last_correct_o,
    output logic [CNT_W-1:0]    score_o,
    output logic [LIV_W-1:0]    lives_left_o,
    output logic [CNT_W-1:0]    round_idx_o,
    output logic                game_over_o,
    output logic                win_o
);

    state_e              state_q, state_d;
    logic [TICK_W-1:0]   window_q, window_d;
    logic [CNT_W-1:0]    score_q, score_d;
    logic [CNT_W-1:0]    round_q, round_d;
    logic [LIV_W-1:0]    lives_q, lives_d;
    logic                last_q, last_d;
    logic                result_q, result_d;
    logic [NUM_KEYS-1:0] key_q, key_d;

    logic              tmr_load;
    logic [TICK_W-1:0] tmr_val;
    logic              tmr_expire;

    phase_timer #(
        .TICK_W (TICK_W)
    ) u_phase_timer (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .tick_i     (tick_i),
        .expire_o   (tmr_expire)
    );

    always_comb begin
        state_d  = state_q;
        window_d = window_q;
        score_d  = score_q;
        round_d  = round_q;
        lives_d  = lives_q;
        last_d   = last_q;
        result_d = result_q;
        key_d    = key_q;
        tmr_load = 1'b0;
        tmr_val  = window_q;

        case (state_q)
            StIdle: begin
                if (start_i) state_d = StInit;
            end
            StInit: begin
                score_d  = '0;
                round_d  = '0;
                lives_d  = LIV_W'(LIVES);
                window_d = TICK_W'(RESP_INIT);
                tmr_load = 1'b1;
                tmr_val  = TICK_W'(START_TICKS);
                state_d  = StStart;
            end
            StStart: begin
                if (tmr_expire) state_d = StClrStart;
            end
            StClrStart: begin
                if (clear_done_i) state_d = StInstr;
            end
            StInstr: begin
                tmr_load = 1'b1;
                key_d    = '0;
                state_d  = StWaitIn;
            end
            StWaitIn: begin
                // A key arriving on the expiring tick still counts as a response.
                if (user_input_i != '0) begin
                    key_d   = user_input_i;
                    state_d = StRelease;
                end else if (tmr_expire) begin
                    result_d = expect_none_i;
                    state_d  = StClrInstr;
                end
            end
            StRelease: begin
                if (user_input_i == '0) begin
                    result_d = (|(key_q & expected_mask_i)) & ~expect_none_i;
                    state_d  = StClrInstr;
                end
            end
            StClrInstr: begin
                if (clear_done_i) begin
                    last_d = result_q;
                    if (result_q) begin
                        if (score_q < CNT_W'(ROUNDS)) score_d = score_q + CNT_W'(1);
                    end else if (lives_q != '0) begin
                        lives_d = lives_q - LIV_W'(1);
                    end
                    if (round_q < CNT_W'(ROUNDS)) round_d = round_q + CNT_W'(1);
                    tmr_load = 1'b1;
                    tmr_val  = TICK_W'(FEED_TICKS);
                    state_d  = StFeedback;
                end
            end
            StFeedback: begin
                if (tmr_expire) begin
                    window_d = (window_q > TICK_W'(RESP_MIN)) ? window_q - TICK_W'(1)
                                                              : TICK_W'(RESP_MIN);
                    state_d  = StClrFeed;
                end
            end
            StClrFeed: begin
                if (clear_done_i) begin
                    state_d = ((lives_q == '0) || (round_q == CNT_W'(ROUNDS))) ? StDone
                                                                              : StInstr;
                end
            end
            StDone: begin
                if (start_i) state_d = StInit;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= StIdle;
            window_q <= TICK_W'(RESP_INIT);
            score_q  <= '0;
            round_q  <= '0;
            lives_q  <= LIV_W'(LIVES);
            last_q   <= 1'b0;
            result_q <= 1'b0;
            key_q    <= '0;
        end else begin
            state_q  <= state_d;
            window_q <= window_d;
            score_q  <= score_d;
            round_q  <= round_d;
            lives_q  <= lives_d;
            last_q   <= last_d;
            result_q <= result_d;
            key_q    <= key_d;
        end
    end

    always_comb begin
        enable_start_o       = (state_q == StStart);
        enable_instruction_o = (state_q == StInstr);
        enable_feedback_o    = (state_q == StFeedback);
        clear_req_o          = (state_q == StClrStart) || (state_q == StClrInstr) ||
                               (state_q == StClrFeed);
        game_over_o          = (state_q == StDone);
        win_o                = (state_q == StDone) && (lives_q != '0);
    end

    assign last_correct_o = last_q;
    assign score_o        = score_q;
    assign lives_left_o   = lives_q;
    assign round_idx_o    = round_q;

endmodule

// File: tb/tb_game_round_controller.sv
// Directed bench for game_round_controller: a game lost on lives, a mid-round
// asynchronous reset, and a full 16-round win.
module tb_game_round_controller;

    logic       clk = 1'b0;
    logic       reset_n, start, tick, clear_done, expect_none;
    logic [5:0] user_input, expected_mask;
    logic       enable_start, enable_instruction, enable_feedback, clear_req;
    logic       last_correct, game_over, win;
    logic [4:0] score, round_idx;
    logic [1:0] lives_left;

    int n_checks = 0;
    int n_fail   = 0;
    int instr_cnt = 0;
    int st_ticks  = 0;
    int wt_ticks  = 0;
    logic measuring = 1'b0;
    int m_score, m_lives, m_round;

    always #5 clk = ~clk;

    game_round_controller dut (
        .clk_i                (clk),
        .reset_ni             (reset_n),
        .start_i              (start),
        .tick_i               (tick),
        .user_input_i         (user_input),
        .expected_mask_i      (expected_mask),
        .expect_none_i        (expect_none),
        .clear_done_i         (clear_done),
        .enable_start_o       (enable_start),
        .enable_instruction_o (enable_instruction),
        .enable_feedback_o    (enable_feedback),
        .clear_req_o          (clear_req),
        .last_correct_o       (last_correct),
        .score_o              (score),
        .lives_left_o         (lives_left),
        .round_idx_o          (round_idx),
        .game_over_o          (game_over),
        .win_o                (win)
    );

    // One tick every four cycles, changed on the falling edge.
    initial begin
        int tcnt;
        tcnt = 0;
        tick = 1'b0;
        forever begin
            @(negedge clk);
            tcnt = (tcnt + 1) % 4;
            tick = (tcnt == 0);
        end
    end

    // Ticks seen in WAIT_IN: no strobe, no clear, not done, while a round is measured.
    always @(posedge clk) begin
        if (enable_instruction) instr_cnt <= instr_cnt + 1;
        if (tick && enable_start) st_ticks <= st_ticks + 1;
        if (measuring && tick && !enable_start && !enable_instruction && !enable_feedback &&
            !clear_req && !game_over) wt_ticks <= wt_ticks + 1;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_clear();
        int n;
        n = 0;
        while (!clear_req && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_eq("clear_req_timeout", 0, 1);
        clear_done = 1'b1;
        @(negedge clk);
        clear_done = 1'b0;
    endtask

    task automatic wait_instr(input int base);
        int n;
        n = 0;
        while (instr_cnt == base && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_eq("instr_timeout", 0, 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_round(input logic [5:0] key, input logic [5:0] mask, input logic none,
                             input logic poke, input int exp_wt, input logic ok,
                             input logic exp_done);
        int base, wbase;
        expected_mask = mask;
        expect_none   = none;
        base      = instr_cnt;
        wbase     = wt_ticks;
        measuring = 1'b1;
        wait_instr(base);
        if (poke) begin
            start      = 1'b1;
            clear_done = 1'b1;
            @(negedge clk);
            start      = 1'b0;
            clear_done = 1'b0;
        end
        if (key != '0) begin
            @(negedge clk);
            user_input = key;
            repeat (5) @(negedge clk);
            user_input = '0;
        end
        do_clear();
        measuring = 1'b0;
        if (ok) m_score++;
        else if (m_lives > 0) m_lives--;
        m_round++;
        check_eq("last_correct", int'(last_correct), int'(ok));
        check_eq("score", int'(score), m_score);
        check_eq("lives_left", int'(lives_left), m_lives);
        check_eq("round_idx", int'(round_idx), m_round);
        check_eq("enable_feedback", int'(enable_feedback), 1);
        if (exp_wt >= 0) check_eq("window_ticks", wt_ticks - wbase, exp_wt);
        do_clear();
        check_eq("game_over", int'(game_over), int'(exp_done));
        if (exp_done) check_eq("win", int'(win), int'(m_lives != 0));
    endtask

    task automatic begin_game();
        int sbase;
        sbase = st_ticks;
        pulse_start();
        do_clear();
        check_eq("start_ticks", st_ticks - sbase, 3);
        m_score = 0;
        m_lives = 3;
        m_round = 0;
    endtask

    initial begin
        int ibase;
        int base;
        logic [5:0] k, m;
        reset_n       = 1'b0;
        start         = 1'b0;
        clear_done    = 1'b0;
        expect_none   = 1'b0;
        user_input    = '0;
        expected_mask = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_enable_start", int'(enable_start), 0);
        check_eq("rst_clear_req", int'(clear_req), 0);
        check_eq("rst_score", int'(score), 0);
        check_eq("rst_lives", int'(lives_left), 3);
        check_eq("rst_round", int'(round_idx), 0);
        check_eq("rst_last", int'(last_correct), 0);
        check_eq("rst_game_over", int'(game_over), 0);
        check_eq("rst_win", int'(win), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Game 1: lost on lives, exercising the shrinking window.
        ibase = instr_cnt;
        begin_game();
        run_round(6'b000000, 6'b000001, 1'b1, 1'b0, 5, 1'b1, 1'b0);
        check_eq("instr_pulses", instr_cnt - ibase, 1);
        run_round(6'b000001, 6'b000001, 1'b0, 1'b0, -1, 1'b1, 1'b0);
        run_round(6'b000010, 6'b000001, 1'b0, 1'b0, -1, 1'b0, 1'b0);
        run_round(6'b000000, 6'b000100, 1'b1, 1'b0, 2, 1'b1, 1'b0);
        run_round(6'b000000, 6'b000100, 1'b1, 1'b1, 2, 1'b1, 1'b0);
        run_round(6'b000001, 6'b000001, 1'b1, 1'b0, -1, 1'b0, 1'b0);
        run_round(6'b100000, 6'b010000, 1'b0, 1'b0, -1, 1'b0, 1'b1);

        // Restart from DONE: counters restored on the way into START.
        pulse_start();
        @(negedge clk);
        check_eq("restart_enable_start", int'(enable_start), 1);
        check_eq("restart_score", int'(score), 0);
        check_eq("restart_lives", int'(lives_left), 3);
        check_eq("restart_round", int'(round_idx), 0);
        check_eq("restart_game_over", int'(game_over), 0);
        do_clear();
        m_score = 0;
        m_lives = 3;
        m_round = 0;
        run_round(6'b001000, 6'b001000, 1'b0, 1'b0, -1, 1'b1, 1'b0);

        // Asynchronous reset in the middle of WAIT_IN.
        expected_mask = 6'b000001;
        expect_none   = 1'b0;
        base = instr_cnt;
        wait_instr(base);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_score", int'(score), 0);
        check_eq("async_lives", int'(lives_left), 3);
        check_eq("async_round", int'(round_idx), 0);
        check_eq("async_last", int'(last_correct), 0);
        check_eq("async_clear_req", int'(clear_req), 0);
        check_eq("async_feedback", int'(enable_feedback), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Game 3: all 16 rounds correct with two-key masks.
        begin_game();
        for (int i = 0; i < 16; i++) begin
            k = 6'b000001 << ((i + 1) % 6);
            m = k | (6'b000001 << (i % 6));
            run_round(k, m, 1'b0, 1'b0, -1, 1'b1, i == 15);
        end
        check_eq("final_win", int'(win), 1);
        check_eq("final_score", int'(score), 16);
        check_eq("final_round", int'(round_idx), 16);
        check_eq("final_lives", int'(lives_left), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
